// File: rtl/brush_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : brush_pkg
// Purpose : Shared constants, state encoding and row-base helper for the
//           brush writer (square stamp / full-frame clear into an index RAM).
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
package brush_pkg;

  localparam int DEF_H_RES    = 640;  // visible pixels per line
  localparam int DEF_V_RES    = 480;  // visible lines per frame
  localparam int DEF_MAX_SIDE = 16;   // largest brush side in pixels

  localparam int ADDR_W  = 19;          // index-RAM address width
  localparam int BASE_W  = ADDR_W + 1;  // row base carries one spare bit for clipped rows
  localparam int X_W     = 10;
  localparam int Y_W     = 9;
  localparam int SIZE_W  = 4;
  localparam int COLOR_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STAMP = 2'd1,
    ST_CLEAR = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // y * line built from shifted copies of the line length; only used once
  // per command to seed the row base, later rows are reached by adding.
  function automatic logic [BASE_W-1:0] row_base(input logic [Y_W-1:0]    y,
                                                 input logic [BASE_W-1:0] line);
    logic [BASE_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < Y_W; i++) begin
      if (y[i]) acc = acc + (line << i);
    end
    return acc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/brush_addr_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : brush_addr_gen
// Purpose : Raster walker over a rectangle: column/row counters, row-base
//           accumulator, clip flag and last-pixel flag. Exposes the address
//           and clip of the pixel being entered so the caller can register
//           the write on the same edge the counters move.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module brush_addr_gen
  import brush_pkg::*;
#(
  parameter int H_RES = DEF_H_RES,
  parameter int V_RES = DEF_V_RES,
  parameter int COL_W = 11,
  parameter int ROW_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,     // start a new rectangle at (x0, y0)
  input  logic              step_i,     // advance to the next raster pixel
  input  logic [X_W-1:0]    x0_i,
  input  logic [Y_W-1:0]    y0_i,
  input  logic [COL_W-1:0]  xend_i,
  input  logic [ROW_W-1:0]  yend_i,
  output logic [ADDR_W-1:0] nxt_addr_o, // address of the pixel being entered
  output logic              nxt_clip_o, // that pixel lies outside the frame
  output logic              last_o      // current pixel is the rectangle's last
);

  localparam logic [COL_W-1:0]  H_LIM = COL_W'(H_RES);
  localparam logic [ROW_W-1:0]  V_LIM = ROW_W'(V_RES);
  localparam logic [BASE_W-1:0] LINE  = BASE_W'(H_RES);

  logic [COL_W-1:0]  col_q, col_d, x0_q, xend_q;
  logic [ROW_W-1:0]  row_q, row_d, yend_q;
  logic [BASE_W-1:0] base_q, base_d;

  // Next position: reload, or step along the row and wrap back to x0 on the next row.
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    base_d = base_q;
    if (load_i) begin
      col_d  = COL_W'(x0_i);
      row_d  = ROW_W'(y0_i);
      base_d = row_base(y0_i, LINE);
    end else if (step_i) begin
      if (col_q == xend_q) begin
        col_d  = x0_q;
        row_d  = row_q + 1'b1;
        base_d = base_q + LINE;
      end else begin
        col_d  = col_q + 1'b1;
      end
    end
  end

  // Counter and rectangle-bound registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      col_q  <= '0;
      row_q  <= '0;
      base_q <= '0;
      x0_q   <= '0;
      xend_q <= '0;
      yend_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      base_q <= base_d;
      if (load_i) begin
        x0_q   <= COL_W'(x0_i);
        xend_q <= xend_i;
        yend_q <= yend_i;
      end
    end
  end

  assign nxt_addr_o = ADDR_W'(base_d + BASE_W'(col_d));
  assign nxt_clip_o = (col_d >= H_LIM) || (row_d >= V_LIM);
  assign last_o     = (col_q == xend_q) && (row_q == yend_q);

endmodule
`default_nettype wire

// File: rtl/brush_writer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : brush_writer
// Purpose : Accepts stamp/clear commands and streams one index-RAM write per
//           cycle in raster order, clipping pixels that fall off the frame.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module brush_writer
  import brush_pkg::*;
#(
  parameter int H_RES    = DEF_H_RES,
  parameter int V_RES    = DEF_V_RES,
  parameter int MAX_SIDE = DEF_MAX_SIDE
) (
  input  logic               iCLK,
  input  logic               iRST_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_clear,
  input  logic [X_W-1:0]     cmd_x,
  input  logic [Y_W-1:0]     cmd_y,
  input  logic [SIZE_W-1:0]  cmd_size,
  input  logic [COLOR_W-1:0] cmd_color,
  output logic [31:0]        addr_index_out,
  output logic [31:0]        data_index_out,
  output logic               ctrl_index_write_enable,
  output logic               busy,
  output logic               done
);

  // Counters must reach the far corner of a square anchored at the largest x/y.
  localparam int COL_W = $clog2((1 << X_W) + MAX_SIDE);
  localparam int ROW_W = $clog2((1 << Y_W) + MAX_SIDE);

  state_t             state_q;
  logic [COLOR_W-1:0] color_q;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [COLOR_W-1:0] data_q;

  logic               accept, step, pixel;
  logic [X_W-1:0]     x0;
  logic [Y_W-1:0]     y0;
  logic [COL_W-1:0]   xend;
  logic [ROW_W-1:0]   yend;
  logic [ADDR_W-1:0]  nxt_addr;
  logic               nxt_clip, last;
  logic [COLOR_W-1:0] pixel_color;

  assign accept = cmd_valid && (state_q == ST_IDLE);
  assign step   = ((state_q == ST_STAMP) || (state_q == ST_CLEAR)) && !last;
  assign pixel  = accept || step;

  // A clear is just a frame-sized rectangle; command coordinates are ignored.
  assign x0   = cmd_clear ? '0 : cmd_x;
  assign y0   = cmd_clear ? '0 : cmd_y;
  assign xend = cmd_clear ? COL_W'(H_RES - 1) : COL_W'(cmd_x) + COL_W'(cmd_size);
  assign yend = cmd_clear ? ROW_W'(V_RES - 1) : ROW_W'(cmd_y) + ROW_W'(cmd_size);

  // The first pixel is written on the accept edge, before color_q is loaded.
  assign pixel_color = accept ? cmd_color : color_q;

  brush_addr_gen #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_addr_gen (
    .clk_i      (iCLK),
    .rst_ni     (iRST_n),
    .load_i     (accept),
    .step_i     (step),
    .x0_i       (x0),
    .y0_i       (y0),
    .xend_i     (xend),
    .yend_i     (yend),
    .nxt_addr_o (nxt_addr),
    .nxt_clip_o (nxt_clip),
    .last_o     (last)
  );

  // Command FSM with registered write port; addr/data hold while no write.
  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      state_q <= ST_IDLE;
      color_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      we_q <= 1'b0;
      if (pixel && !nxt_clip) begin
        we_q   <= 1'b1;
        addr_q <= nxt_addr;
        data_q <= pixel_color;
      end
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            color_q <= cmd_color;
            state_q <= cmd_clear ? ST_CLEAR : ST_STAMP;
          end
        end
        ST_STAMP, ST_CLEAR: begin
          if (last) state_q <= ST_DONE;
        end
        ST_DONE:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready               = (state_q == ST_IDLE);
  assign busy                    = (state_q != ST_IDLE);
  assign done                    = (state_q == ST_DONE);
  assign ctrl_index_write_enable = we_q;
  assign addr_index_out          = {{(32 - ADDR_W){1'b0}}, addr_q};
  assign data_index_out          = {{(32 - COLOR_W){1'b0}}, data_q};

endmodule
`default_nettype wire

// File: doc/brush_writer.md
BRUSH_WRITER -- requirements
Module: brush_writer

Interface
REQ-001 SHALL have parameter H_RES, default 640: visible pixels per line.
REQ-002 SHALL have parameter V_RES, default 480: visible lines per frame.
REQ-003 SHALL have parameter MAX_SIDE, default 16: largest brush side in pixels.
REQ-004 SHALL have port iCLK  in  1: single clock; all logic is on its rising edge.
REQ-005 SHALL have port iRST_n  in  1: synchronous, active-low reset.
REQ-006 SHALL have port cmd_valid  in  1: a command is presented.
REQ-007 SHALL have port cmd_ready  out  1: the block accepts a command this cycle.
REQ-008 SHALL have port cmd_clear  in  1: 1 = fill the whole frame; 0 = stamp a square.
REQ-009 SHALL have port cmd_x  in  10: top-left column of the square.
REQ-010 SHALL have port cmd_y  in  9: top-left row of the square.
REQ-011 SHALL have port cmd_size  in  4: square side minus 1, so the side is 1..16.
REQ-012 SHALL have port cmd_color  in  8: palette index to write.
REQ-013 SHALL have port addr_index_out  out  32: index-RAM write address; bits [31:19] are 0.
REQ-014 SHALL have port data_index_out  out  32: write data, {24'b0, color}.
REQ-015 SHALL have port ctrl_index_write_enable  out  1: write strobe, one pixel per cycle.
REQ-016 SHALL have port busy  out  1: a command is in progress.
REQ-017 SHALL have port done  out  1: one-cycle pulse when a command completes.

Function
REQ-018 SHALL implement the states IDLE, STAMP, CLEAR and DONE.
REQ-019 SHALL hold cmd_ready=1 only in IDLE; a command is accepted on a cycle with cmd_valid&&cmd_ready.
REQ-020 SHALL, on acceptance, latch all cmd_* inputs and go to CLEAR if cmd_clear=1, otherwise to STAMP.
REQ-021 SHALL ignore cmd_valid while busy, with no queuing.
REQ-022 SHALL visit pixels in STAMP in raster order: col from cmd_x to cmd_x+size, then row from cmd_y to cmd_y+size.
REQ-023 SHALL spend exactly (size+1)^2 cycles in STAMP.
REQ-024 SHALL visit every pixel in CLEAR in raster order from address 0 to H_RES*V_RES-1, spending exactly H_RES*V_RES cycles.
REQ-025 SHALL present the first pixel's write in the cycle after acceptance, i.e. latency 1.
REQ-026 SHALL compute the address as row*H_RES+col using an incrementally maintained row base (+H_RES per row), with no multiplier.
REQ-027 SHALL clip: a pixel with col>=H_RES or row>=V_RES produces write_enable=0 but still consumes its cycle.
REQ-028 SHALL not wrap any coordinate across a line or frame edge.
REQ-029 SHALL keep addr and data at their last values while write_enable=0.
REQ-030 SHALL enter DONE after the last pixel, assert done=1 for exactly that one cycle, then return to IDLE.
REQ-031 SHALL drive busy=1 in STAMP, CLEAR and DONE.
REQ-032 SHALL NOT write any pixel twice, and no address SHALL exceed H_RES*V_RES-1.

Reset
REQ-033 SHALL, when iRST_n=0 at a clock edge, go to IDLE with cmd_ready=1, busy=0, done=0, write_enable=0, addr=0, data=0.
REQ-034 SHALL, on reset mid-command, abort the command with no further writes and no done pulse.

Structure
REQ-035 SHALL place H_RES, V_RES, MAX_SIDE, address width 19 and the state enum in the shared package brush_pkg.
REQ-036 SHALL use one sub-module, brush_addr_gen: row/col counters, row-base accumulator, clip flag and last-pixel flag; the FSM stays in brush_writer.

Verification
REQ-037 SHALL cover: stamp (0,0), size 0, color 5 -> one write, addr 0, data 5, in the cycle after acceptance; done one cycle later.
REQ-038 SHALL cover: stamp (10,2), size 2 -> 9 consecutive writes at 1290-1292, 1930-1932, 2570-2572; done once.
REQ-039 SHALL cover: stamp (638,478), size 3 -> 16 cycles; writes only at 306558, 306559, 307198, 307199.
REQ-040 SHALL cover: clear, color 0x2A -> 307200 writes from addr 0 to 307199, all data 0x2A; then done.
REQ-041 SHALL cover: iRST_n=0 on the 4th write of a size-3 stamp -> next cycle write_enable=0, cmd_ready=1, no done pulse.
REQ-042 SHALL cover: cmd_valid held high during a stamp -> second command accepted only in the cycle after done.
